// File: rtl/ptr_sync_flag_gen_if.sv
// Pointer/flag bundle between a FIFO pointer generator and its sync/flag block.
// The master side drives the pointers; the slave side returns the flags.
interface ptr_sync_flag_gen_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] LOCAL_GRAY;
  logic [WIDTH-1:0] REMOTE_GRAY;
  logic             FLAG;
  logic             ALMOST;
  logic [WIDTH-1:0] LEVEL;
  logic [WIDTH-1:0] REMOTE_BIN;
  logic             ERR;

  modport master (
    output LOCAL_GRAY,
    output REMOTE_GRAY,
    input  FLAG,
    input  ALMOST,
    input  LEVEL,
    input  REMOTE_BIN,
    input  ERR
  );

  modport slave (
    input  LOCAL_GRAY,
    input  REMOTE_GRAY,
    output FLAG,
    output ALMOST,
    output LEVEL,
    output REMOTE_BIN,
    output ERR
  );
endinterface

// File: rtl/ptr_sync_flag_gen.sv
// Synchronizes the remote gray pointer, decodes occupancy and drives registered
// empty (MODE=0) or full (MODE=1) flags back to the local pointer generator.
module ptr_sync_flag_gen #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int MODE          = 0,
  parameter int ALMOST_THRESH = 4
) (
  input logic               CLK,
  input logic               RST,
  ptr_sync_flag_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] DEPTH    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] THRESH   = WIDTH'(ALMOST_THRESH);
  localparam logic [WIDTH-1:0] FULL_LVL = DEPTH - THRESH;
  localparam logic             RST_FLAG = (MODE == 0);

  if (WIDTH < 3) begin : g_bad_width
    $error("ptr_sync_flag_gen: WIDTH must be at least 3");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("ptr_sync_flag_gen: SYNC_STAGES must be 2..4");
  end
  if (ALMOST_THRESH < 1 || ALMOST_THRESH > (2**(WIDTH-1)) - 1) begin : g_bad_thresh
    $error("ptr_sync_flag_gen: ALMOST_THRESH out of range");
  end

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] rsync;
  logic [WIDTH-1:0] rsync_bin;
  logic [WIDTH-1:0] local_bin;
  logic [WIDTH-1:0] full_pat;
  logic [WIDTH-1:0] level_nxt;
  logic             flag_nxt;
  logic             almost_nxt;
  logic             err_nxt;

  logic             flag_q;
  logic             almost_q;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] remote_bin_q;
  logic             err_q;

  // Plain flop chain: nothing may sit between stages of the synchronizer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.REMOTE_GRAY;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    rsync     = sync_q[SYNC_STAGES-1];
    rsync_bin = gray2bin(rsync);
    local_bin = gray2bin(bus.LOCAL_GRAY);
    // Full when the pointers differ only in the top two gray bits (wrap bit set apart).
    full_pat  = {~rsync[WIDTH-1:WIDTH-2], rsync[WIDTH-3:0]};
    if (MODE == 0) begin
      level_nxt  = rsync_bin - local_bin;
      flag_nxt   = (bus.LOCAL_GRAY == rsync);
      almost_nxt = (level_nxt <= THRESH);
    end else begin
      level_nxt  = local_bin - rsync_bin;
      flag_nxt   = (bus.LOCAL_GRAY == full_pat);
      almost_nxt = (level_nxt >= FULL_LVL);
    end
    err_nxt = (level_nxt > DEPTH);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flag_q       <= RST_FLAG;
      almost_q     <= RST_FLAG;
      level_q      <= '0;
      remote_bin_q <= '0;
      err_q        <= 1'b0;
    end else begin
      flag_q       <= flag_nxt;
      almost_q     <= almost_nxt;
      level_q      <= level_nxt;
      remote_bin_q <= rsync_bin;
      err_q        <= err_q | err_nxt;
    end
  end

  assign bus.FLAG       = flag_q;
  assign bus.ALMOST     = almost_q;
  assign bus.LEVEL      = level_q;
  assign bus.REMOTE_BIN = remote_bin_q;
  assign bus.ERR        = err_q;

endmodule

// File: tb/tb_ptr_sync_flag_gen.sv
// Directed and randomized checks of a read-side and a write-side instance against
// an occupancy model built from binary pointers and a remote-sample delay queue.
module tb_ptr_sync_flag_gen;
  localparam int W     = 8;
  localparam int SS    = 2;
  localparam int TH    = 4;
  localparam int DEPTH = 1 << (W-1);

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0] loc_b [2];
  logic [W-1:0] rem_b [2];

  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  logic [W-1:0] e_level [2];
  logic [W-1:0] e_rbin [2];
  logic         e_flag [2];
  logic         e_almost [2];
  logic         e_err [2];
  bit           in_rst = 1'b0;

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  ptr_sync_flag_gen_if #(.WIDTH(W)) if_rd ();
  ptr_sync_flag_gen_if #(.WIDTH(W)) if_wr ();

  assign if_rd.LOCAL_GRAY  = b2g(loc_b[0]);
  assign if_rd.REMOTE_GRAY = b2g(rem_b[0]);
  assign if_wr.LOCAL_GRAY  = b2g(loc_b[1]);
  assign if_wr.REMOTE_GRAY = b2g(rem_b[1]);

  ptr_sync_flag_gen #(.WIDTH(W), .SYNC_STAGES(SS), .MODE(0), .ALMOST_THRESH(TH)) u_rd (
    .CLK (CLK),
    .RST (RST),
    .bus (if_rd.slave)
  );

  ptr_sync_flag_gen #(.WIDTH(W), .SYNC_STAGES(SS), .MODE(1), .ALMOST_THRESH(TH)) u_wr (
    .CLK (CLK),
    .RST (RST),
    .bus (if_wr.slave)
  );

  always #5 CLK = ~CLK;

  task automatic set_reset_exp();
    for (int m = 0; m < 2; m++) begin
      e_level[m]  = '0;
      e_rbin[m]   = '0;
      e_flag[m]   = (m == 0);
      e_almost[m] = (m == 0);
      e_err[m]    = 1'b0;
    end
  endtask

  task automatic flush_queues();
    q0 = {};
    q1 = {};
    for (int i = 0; i < SS; i++) begin
      q0.push_back('0);
      q1.push_back('0);
    end
  endtask

  // Occupancy = entries written but not yet read, as seen from this side.
  task automatic model_eval(input int m, input logic [W-1:0] lb, input logic [W-1:0] rb);
    int lvl;
    lvl = (m == 0) ? int'(rb) - int'(lb) : int'(lb) - int'(rb);
    if (lvl < 0) lvl += (1 << W);
    e_level[m]  = W'(lvl);
    e_rbin[m]   = rb;
    e_flag[m]   = (m == 0) ? (lvl == 0) : (lvl == DEPTH);
    e_almost[m] = (m == 0) ? (lvl <= TH) : (lvl >= DEPTH - TH);
    if (lvl > DEPTH) e_err[m] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd.flag"},   W'(if_rd.FLAG),   W'(e_flag[0]));
    chk({tag, ".rd.almost"}, W'(if_rd.ALMOST), W'(e_almost[0]));
    chk({tag, ".rd.level"},  if_rd.LEVEL,      e_level[0]);
    chk({tag, ".rd.rbin"},   if_rd.REMOTE_BIN, e_rbin[0]);
    chk({tag, ".rd.err"},    W'(if_rd.ERR),    W'(e_err[0]));
    chk({tag, ".wr.flag"},   W'(if_wr.FLAG),   W'(e_flag[1]));
    chk({tag, ".wr.almost"}, W'(if_wr.ALMOST), W'(e_almost[1]));
    chk({tag, ".wr.level"},  if_wr.LEVEL,      e_level[1]);
    chk({tag, ".wr.rbin"},   if_wr.REMOTE_BIN, e_rbin[1]);
    chk({tag, ".wr.err"},    W'(if_wr.ERR),    W'(e_err[1]));
  endtask

  task automatic tick(input string tag);
    logic [W-1:0] rs0;
    logic [W-1:0] rs1;
    @(posedge CLK);
    q0.push_back(rem_b[0]);
    q1.push_back(rem_b[1]);
    rs0 = q0.pop_front();
    rs1 = q1.pop_front();
    if (!in_rst) begin
      model_eval(0, loc_b[0], rs0);
      model_eval(1, loc_b[1], rs1);
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    #2;
    RST    = 1'b1;
    in_rst = 1'b1;
    set_reset_exp();
    #1;
    check_all({tag, ".async"});
    tick({tag, ".held"});
    @(negedge CLK);
    RST    = 1'b0;
    in_rst = 1'b0;
    flush_queues();
  endtask

  initial begin
    int wp;
    int rp;
    for (int m = 0; m < 2; m++) begin
      loc_b[m] = '0;
      rem_b[m] = '0;
    end
    flush_queues();
    set_reset_exp();

    // Reset and idle with both pointers at zero.
    do_reset("t1");
    repeat (3) tick("t1.idle");

    // Read side: remote steps to 1 then 5.
    rem_b[0] = 8'd1;
    repeat (3) tick("t2.step1");
    rem_b[0] = 8'd5;
    repeat (3) tick("t2.step5");

    // Write side: local jumps to half-wrap, then remote reads one entry.
    loc_b[1] = 8'd128;
    tick("t3.full");
    rem_b[1] = 8'd1;
    repeat (3) tick("t3.drain");

    // Read side wrap-around.
    loc_b[0] = 8'd254;
    repeat (3) tick("t4.pre");
    rem_b[0] = 8'd3;
    repeat (3) tick("t4.wrap");
    loc_b[0] = 8'd3;
    repeat (2) tick("t4.empty");

    // Write side overflow error is sticky until reset.
    loc_b[1] = 8'd200;
    rem_b[1] = 8'd0;
    repeat (3) tick("t5.err");
    loc_b[1] = 8'd10;
    repeat (3) tick("t5.sticky");
    do_reset("t5");
    repeat (2) tick("t5.after");

    // Mid-operation reset while a remote change is in flight.
    loc_b[0] = 8'd0;
    rem_b[0] = 8'd20;
    repeat (4) tick("t6.pre");
    rem_b[0] = 8'd30;
    tick("t6.inflight");
    do_reset("t6");
    repeat (4) tick("t6.post");

    // Randomized FIFO traffic: write-biased then read-biased.
    do_reset("rnd");
    wp = 0;
    rp = 0;
    for (int i = 0; i < 400; i++) begin
      int wr_pct;
      wr_pct = (i < 200) ? 75 : 25;
      if ($urandom_range(99, 0) < wr_pct && (wp - rp) < DEPTH) wp++;
      if ($urandom_range(99, 0) >= wr_pct && (wp - rp) > 0) rp++;
      loc_b[0] = W'(rp);
      rem_b[0] = W'(wp);
      loc_b[1] = W'(wp);
      rem_b[1] = W'(rp);
      tick("rnd.fifo");
    end

    // Arbitrary pointer jumps, including illegal occupancies.
    for (int i = 0; i < 40; i++) begin
      loc_b[0] = W'($urandom);
      rem_b[0] = W'($urandom);
      loc_b[1] = W'($urandom);
      rem_b[1] = W'($urandom);
      tick("rnd.jump");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ptr_sync_flag_gen.md
Name: ptr_sync_flag_gen

Overview:
Consumer of the gray pointer produced by the FIFO pointer generator on the opposite clock domain.
- Synchronizes the remote gray pointer into the local CLK domain.
- Decodes both local and remote gray pointers to binary and computes FIFO occupancy.
- Drives the registered FULL/EMPTY FLAG, plus ALMOST, LEVEL and a sticky overflow error, back to the local pointer generator.
- One instance sits on the write side (MODE=1, full) and one on the read side (MODE=0, empty).

Parameters:
- WIDTH, 8, pointer width including wrap bit; FIFO depth = 2^(WIDTH-1).
- SYNC_STAGES, 2, remote-pointer synchronizer depth; legal range 2..4.
- MODE, 0, 0 = read side (FLAG means empty), 1 = write side (FLAG means full).
- ALMOST_THRESH, 4, ALMOST margin in entries; legal range 1..2^(WIDTH-1)-1.

Ports:
- CLK  in  1  local domain clock.
- RST  in  1  asynchronous reset, active-high.
- LOCAL_GRAY  in  WIDTH  gray pointer of this domain; synchronous to CLK.
- REMOTE_GRAY  in  WIDTH  gray pointer from the other domain; asynchronous to CLK.
- FLAG  out  1  MODE=0: empty; MODE=1: full. Low means not empty/full.
- ALMOST  out  1  MODE=0: LEVEL <= ALMOST_THRESH; MODE=1: LEVEL >= DEPTH-ALMOST_THRESH.
- LEVEL  out  WIDTH  registered occupancy, 0..DEPTH.
- REMOTE_BIN  out  WIDTH  registered binary of the synchronized remote pointer.
- ERR  out  1  sticky: computed occupancy exceeded DEPTH.

Behaviour:
- Reset (RST=1, async assert): all synchronizer stages, REMOTE_BIN and LEVEL go to 0. ERR=0. ALMOST=1 if MODE=0 else 0. FLAG=1 if MODE=0 else 0. Deassertion of RST is taken synchronously on the next CLK edge.
- Synchronizer: shift chain of SYNC_STAGES flops on REMOTE_GRAY. No logic between stages. Only the last stage (RSYNC) is consumed.
- Gray-to-binary, for both RSYNC and LOCAL_GRAY: bin[WIDTH-1] = gray[WIDTH-1]; bin[i] = bin[i+1] ^ gray[i].
- Occupancy, modulo 2^WIDTH with WIDTH-bit unsigned wrap:
  - MODE=0: LEVEL_NXT = RSYNC_BIN - LOCAL_BIN (write minus read).
  - MODE=1: LEVEL_NXT = LOCAL_BIN - RSYNC_BIN.
- FLAG_NXT, compared on gray codes, not on LEVEL:
  - MODE=0: LOCAL_GRAY == RSYNC.
  - MODE=1: LOCAL_GRAY == {~RSYNC[WIDTH-1:WIDTH-2], RSYNC[WIDTH-3:0]}.
- FLAG, ALMOST, LEVEL and REMOTE_BIN are all registered on the CLK posedge; no combinational path from any input to any output.
- Latency:
  - LOCAL_GRAY change reaches outputs after 1 CLK edge.
  - REMOTE_GRAY change reaches outputs after SYNC_STAGES+1 edges.
- Pessimism is intentional. The local side asserts FLAG immediately on its own move; deassertion waits for the synchronized remote move.
- ERR: set when LEVEL_NXT > DEPTH. Stays at 1 until RST. FLAG/LEVEL keep computing normally while ERR=1.
- Wrap-around: pointers wrap from 2^WIDTH-1 to 0. LEVEL stays correct across the wrap through the modulo subtraction. The wrap bit (MSB) distinguishes full from empty when the address bits are equal.
- Simultaneous local and remote changes in one cycle: both are used in the same evaluation. There is no priority and no special case.
- Reset mid-operation: outputs return to reset values within the same cycle (async). The synchronizer is flushed. After release, the first valid remote-derived output appears SYNC_STAGES+1 edges later.
- WIDTH >= 3 is required; elaboration fails otherwise.

Test Plan:
1. Reset, MODE=0, WIDTH=8: assert RST mid-clock -> FLAG=1, ALMOST=1, LEVEL=0, ERR=0 immediately. Release, hold both pointers at 0 -> outputs unchanged.
2. MODE=0, REMOTE_GRAY steps 0 -> gray(1) -> gray(5) (binary 5) -> FLAG falls 3 edges after the first step. LEVEL=5 and ALMOST=0 after 3 edges from the last step (THRESH=4).
3. MODE=1, LOCAL_GRAY = gray(128), REMOTE_GRAY = 0 held -> FLAG=1 and LEVEL=128 after 1 edge. REMOTE_GRAY = gray(1) -> FLAG=0 and LEVEL=127 after 3 edges.
4. Wrap: MODE=0, local=gray(254), remote steps to gray(3) (binary 3, wrapped) -> LEVEL=5, FLAG=0. Local advances to gray(3) -> FLAG=1 and LEVEL=0 one edge later.
5. Error: MODE=1, local=gray(200), remote=0 -> ERR=1 after 1 edge. Restore local=gray(10) -> ERR stays 1, LEVEL=10. Pulse RST -> ERR=0.
6. Mid-operation reset: MODE=0 with LEVEL=20 during a remote pointer change -> all outputs at reset values asynchronously. After release, outputs are taken from the new remote pointer only, exactly SYNC_STAGES+1 edges later.
